// File: rtl/sample_buffer_reader_if.sv
// Bus bundle for sample_buffer_reader: the s2 read-master port toward the
// sample buffer and the Avalon-ST sample stream toward reconstruction.
interface sample_buffer_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W-1:0]   mem_readdata;

  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_startofpacket;
  logic                out_endofpacket;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata,
    input  mem_readdata,
    output out_data, out_valid, out_startofpacket, out_endofpacket,
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata,
    output mem_readdata,
    input  out_data, out_valid, out_startofpacket, out_endofpacket,
    output out_ready
  );
endinterface

// File: rtl/sample_buffer_reader.sv
// Reads a programmed block of samples from buffer port s2 and streams it out as an
// Avalon-ST packet, one-shot or looped, through a credit-controlled 2-entry FIFO.
module sample_buffer_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W:0]     length_i,
  input  logic                loop_i,
  output logic                busy_o,
  output logic                done_o,
  sample_buffer_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                loop_q, loop_d;
  logic [ADDR_W:0]     offset_q, offset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                rdPend_q, rdPend_d;
  logic                rdSop_q, rdSop_d;
  logic                rdEop_q, rdEop_d;

  logic [DATA_W-1:0]   headData_q, headData_d;
  logic                headSop_q, headSop_d;
  logic                headEop_q, headEop_d;
  logic                headVld_q, headVld_d;
  logic [DATA_W-1:0]   skidData_q, skidData_d;
  logic                skidSop_q, skidSop_d;
  logic                skidEop_q, skidEop_d;
  logic                skidVld_q, skidVld_d;

  logic                pop;
  logic [1:0]          used;
  logic                rdIssue;
  logic                lastOffset;
  logic [ADDR_W:0]     lenSat;

  // Credit: FIFO entries plus the read in flight may never exceed two, except that a
  // pop in the same cycle frees the slot the new read will land in.
  assign pop        = headVld_q & bus.out_ready;
  assign used       = 2'(headVld_q) + 2'(skidVld_q) + 2'(rdPend_q);
  assign rdIssue    = (state_q == RUN) && ((used < 2'd2) || pop);
  assign lastOffset = (offset_q == (len_q - ONE));
  assign lenSat     = (length_i > DEPTH) ? DEPTH : length_i;

  assign bus.mem_chipselect    = rdIssue;
  assign bus.mem_address       = base_q + offset_q[ADDR_W-1:0];
  assign bus.mem_write         = 1'b0;
  assign bus.mem_byteenable    = '1;
  assign bus.mem_writedata     = '0;

  assign bus.out_data          = headData_q;
  assign bus.out_valid         = headVld_q;
  assign bus.out_startofpacket = headSop_q;
  assign bus.out_endofpacket   = headEop_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    loop_d     = loop_q;
    offset_d   = offset_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    headData_d = headData_q;
    headSop_d  = headSop_q;
    headEop_d  = headEop_q;
    skidData_d = skidData_q;
    skidSop_d  = skidSop_q;
    skidEop_d  = skidEop_q;
    skidVld_d  = skidVld_q;
    rdPend_d   = rdIssue;
    rdSop_d    = (offset_q == '0);
    rdEop_d    = lastOffset;

    // Head is the output register; the skid entry refills it before new data does.
    headVld_d = headVld_q & ~pop;
    if (!headVld_d && skidVld_q) begin
      headData_d = skidData_q;
      headSop_d  = skidSop_q;
      headEop_d  = skidEop_q;
      headVld_d  = 1'b1;
      skidVld_d  = 1'b0;
    end
    if (rdPend_q) begin
      if (!headVld_d) begin
        headData_d = bus.mem_readdata;
        headSop_d  = rdSop_q;
        headEop_d  = rdEop_q;
        headVld_d  = 1'b1;
      end else begin
        skidData_d = bus.mem_readdata;
        skidSop_d  = rdSop_q;
        skidEop_d  = rdEop_q;
        skidVld_d  = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          base_d   = base_addr_i;
          len_d    = lenSat;
          loop_d   = loop_i;
          offset_d = '0;
          if (lenSat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (rdIssue) begin
          if (lastOffset && loop_q) begin
            offset_d = '0;
          end else begin
            offset_d = offset_q + ONE;
            if (lastOffset) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop && headEop_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a same-cycle completion.
    if (stop_i) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      headVld_d = 1'b0;
      skidVld_d = 1'b0;
      rdPend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      offset_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdPend_q   <= 1'b0;
      rdSop_q    <= 1'b0;
      rdEop_q    <= 1'b0;
      headData_q <= '0;
      headSop_q  <= 1'b0;
      headEop_q  <= 1'b0;
      headVld_q  <= 1'b0;
      skidData_q <= '0;
      skidSop_q  <= 1'b0;
      skidEop_q  <= 1'b0;
      skidVld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      offset_q   <= offset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdPend_q   <= rdPend_d;
      rdSop_q    <= rdSop_d;
      rdEop_q    <= rdEop_d;
      headData_q <= headData_d;
      headSop_q  <= headSop_d;
      headEop_q  <= headEop_d;
      headVld_q  <= headVld_d;
      skidData_q <= skidData_d;
      skidSop_q  <= skidSop_d;
      skidEop_q  <= skidEop_d;
      skidVld_q  <= skidVld_d;
    end
  end

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Directed bench for sample_buffer_reader: a buffer model answers s2 reads, a
// scoreboard queue holds expected samples and a negedge monitor checks the stream.
module tb_sample_buffer_reader;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [8:0] baseAddr;
  logic [9:0] length;
  logic       loopEn;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int issuedCount = 0;
  int acceptedCount = 0;
  int maxOutstanding = 0;
  bit bpMode = 0;
  int bpPhase = 0;
  logic [3:0] bpPattern = 4'b1001;

  exp_t       expQ[$];
  logic [8:0] addrLog[$];
  logic [15:0] mem[512];

  sample_buffer_reader_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  sample_buffer_reader #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start),
    .stop_i      (stop),
    .base_addr_i (baseAddr),
    .length_i    (length),
    .loop_i      (loopEn),
    .busy_o      (busy),
    .done_o      (done),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
  end

  always @(posedge clk) begin
    if (bus.mem_chipselect) bus.mem_readdata <= mem[bus.mem_address];
  end

  // Monitor: every accepted sample must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if ((issuedCount - acceptedCount) > maxOutstanding)
        maxOutstanding = issuedCount - acceptedCount;
      if (bus.mem_chipselect) begin
        issuedCount++;
        addrLog.push_back(bus.mem_address);
      end
      if (bus.out_valid && bus.out_ready) begin
        acceptedCount++;
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected sample: got data=%h sop=%0b eop=%0b, required none",
                   bus.out_data, bus.out_startofpacket, bus.out_endofpacket);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          if (bus.out_data !== e.data || bus.out_startofpacket !== e.sop ||
              bus.out_endofpacket !== e.eop) begin
            miscompares++;
            $display("[TB] FAIL stream sample: got data=%h sop=%0b eop=%0b, required data=%h sop=%0b eop=%0b",
                     bus.out_data, bus.out_startofpacket, bus.out_endofpacket, e.data, e.sop, e.eop);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bpMode) begin
      bus.out_ready = bpPattern[bpPhase];
      bpPhase = (bpPhase + 1) % 4;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic pushBlock(input int base, input int len, input int count);
    for (int i = 0; i < count; i++) begin
      exp_t e;
      int off;
      off = i % len;
      e.data = 16'h1000 + 16'((base + off) % 512);
      e.sop  = (off == 0);
      e.eop  = (off == len - 1);
      expQ.push_back(e);
    end
  endtask

  // Drives a one-cycle start (optionally left high) and returns in cycle 1.
  task automatic applyStimulus(input logic [8:0] base, input logic [9:0] len, input logic lp, input bit keepStart);
    issuedCount = 0;
    acceptedCount = 0;
    addrLog.delete();
    baseAddr = base;
    length   = len;
    loopEn   = lp;
    start    = 1'b1;
    tick();
    if (!keepStart) start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int maxCycles);
    int n = 0;
    while (done !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    baseAddr = '0;
    length = '0;
    loopEn = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset chipselect", 32'(bus.mem_chipselect), 0);
    checkOutput("reset address", 32'(bus.mem_address), 0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 0);
    checkOutput("reset out_data", 32'(bus.out_data), 0);
    reset_n = 1'b1;
    tick();

    // One-shot block of 4 with exact cycle timing.
    pushBlock(9'h010, 4, 4);
    applyStimulus(9'h010, 10'd4, 1'b0, 0);
    checkOutput("t1 chipselect c1", 32'(bus.mem_chipselect), 1);
    checkOutput("t1 address c1", 32'(bus.mem_address), 32'h010);
    checkOutput("t1 busy c1", 32'(busy), 1);
    tick();
    tick();
    checkOutput("t1 out_valid c3", 32'(bus.out_valid), 1);
    checkOutput("t1 out_data c3", 32'(bus.out_data), 32'h1010);
    checkOutput("t1 sop c3", 32'(bus.out_startofpacket), 1);
    tick();
    tick();
    tick();
    checkOutput("t1 out_data c6", 32'(bus.out_data), 32'h1013);
    checkOutput("t1 eop c6", 32'(bus.out_endofpacket), 1);
    checkOutput("t1 done c6", 32'(done), 0);
    tick();
    checkOutput("t1 done c7", 32'(done), 1);
    checkOutput("t1 busy c7", 32'(busy), 0);
    checkOutput("t1 out_valid c7", 32'(bus.out_valid), 0);
    tick();
    checkOutput("t1 done c8", 32'(done), 0);
    checkOutput("t1 drained", 32'(expQ.size()), 0);

    // Address wrap at the top of the buffer.
    pushBlock(9'h1FE, 4, 4);
    applyStimulus(9'h1FE, 10'd4, 1'b0, 0);
    waitDone("wrap done", 20);
    checkOutput("wrap reads", 32'(addrLog.size()), 4);
    if (addrLog.size() == 4) begin
      checkOutput("wrap addr0", 32'(addrLog[0]), 32'h1FE);
      checkOutput("wrap addr1", 32'(addrLog[1]), 32'h1FF);
      checkOutput("wrap addr2", 32'(addrLog[2]), 32'h000);
      checkOutput("wrap addr3", 32'(addrLog[3]), 32'h001);
    end
    checkOutput("wrap drained", 32'(expQ.size()), 0);

    // Backpressure with ready pattern 1,0,0,1.
    pushBlock(9'h020, 8, 8);
    bpMode = 1;
    bpPhase = 0;
    applyStimulus(9'h020, 10'd8, 1'b0, 0);
    waitDone("bp done", 80);
    bpMode = 0;
    bus.out_ready = 1'b1;
    checkOutput("bp drained", 32'(expQ.size()), 0);
    checkOutput("bp reads issued", 32'(issuedCount), 8);
    tick();

    // Looped playback, stopped after 7 accepted samples.
    pushBlock(0, 3, 7);
    applyStimulus(9'h000, 10'd3, 1'b1, 0);
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      checkOutput("loop gapless", 32'(bus.out_valid), 1);
      tick();
    end
    checkOutput("loop accepted", 32'(acceptedCount), 7);
    stop = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    stop = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("stop out_valid", 32'(bus.out_valid), 0);
    checkOutput("stop busy", 32'(busy), 0);
    checkOutput("stop done", 32'(done), 0);
    tick();
    checkOutput("stop done later", 32'(done), 0);
    checkOutput("stop chipselect", 32'(bus.mem_chipselect), 0);
    checkOutput("loop drained", 32'(expQ.size()), 0);

    // Zero length: done only, no reads.
    applyStimulus(9'h033, 10'd0, 1'b0, 0);
    checkOutput("len0 done", 32'(done), 1);
    checkOutput("len0 busy", 32'(busy), 0);
    checkOutput("len0 chipselect", 32'(bus.mem_chipselect), 0);
    tick();
    checkOutput("len0 done clears", 32'(done), 0);
    checkOutput("len0 no reads", 32'(issuedCount), 0);

    // Oversized length saturates to the buffer depth.
    pushBlock(9'h005, 512, 512);
    applyStimulus(9'h005, 10'd600, 1'b0, 0);
    waitDone("len600 done", 600);
    checkOutput("len600 samples", 32'(acceptedCount), 512);
    checkOutput("len600 drained", 32'(expQ.size()), 0);
    tick();

    // Start held high (with changing parameters) while busy must not restart.
    pushBlock(9'h080, 8, 8);
    applyStimulus(9'h080, 10'd8, 1'b0, 1);
    for (int i = 0; i < 6; i++) begin
      baseAddr = 9'h100;
      length = 10'd2;
      checkOutput("held start busy", 32'(busy), 1);
      tick();
    end
    start = 1'b0;
    waitDone("held start done", 30);
    tick();
    tick();
    checkOutput("held start idle", 32'(bus.out_valid), 0);
    checkOutput("held start samples", 32'(acceptedCount), 8);
    checkOutput("held start drained", 32'(expQ.size()), 0);

    // Asynchronous reset mid-block.
    pushBlock(9'h040, 16, 16);
    applyStimulus(9'h040, 10'd16, 1'b0, 0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("pre-reset out_valid", 32'(bus.out_valid), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async busy", 32'(busy), 0);
    checkOutput("async done", 32'(done), 0);
    checkOutput("async chipselect", 32'(bus.mem_chipselect), 0);
    checkOutput("async address", 32'(bus.mem_address), 0);
    checkOutput("async out_valid", 32'(bus.out_valid), 0);
    checkOutput("async out_data", 32'(bus.out_data), 0);
    checkOutput("async sop", 32'(bus.out_startofpacket), 0);
    checkOutput("async eop", 32'(bus.out_endofpacket), 0);
    expQ.delete();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("post-reset busy", 32'(busy), 0);
    checkOutput("post-reset out_valid", 32'(bus.out_valid), 0);
    checkOutput("post-reset chipselect", 32'(bus.mem_chipselect), 0);

    checkOutput("max outstanding", 32'(maxOutstanding <= 2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_buffer_reader.md
# sample_buffer_reader

Avalon-MM read master for the second port (s2) of the 512x16 dual-port sample buffer. The HPS or another bus master fills the buffer through s1. This block fetches a programmed block of samples through s2 and emits them as an Avalon-ST packet toward the signal-reconstruction datapath. It supports one-shot or looped playback, honours downstream backpressure, and wraps addresses modulo the buffer depth.

## Interface
Parameters:
- ADDR_W, 9, buffer address width; depth = 2^ADDR_W words
- DATA_W, 16, sample width

Ports:
- clk  in  1  single clock for the whole block
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin playback; sampled only in IDLE
- stop  in  1  abort request; honoured in any state
- base_addr  in  ADDR_W  first buffer word of the block; latched on start
- length  in  ADDR_W+1  sample count; latched on start; values above 2^ADDR_W saturate to 2^ADDR_W
- loop  in  1  latched on start; 1 = replay the block until stop
- busy  out  1  high from the cycle after an accepted start until completion or abort
- done  out  1  one-cycle pulse on normal completion
- mem_address  out  ADDR_W  s2 address
- mem_chipselect  out  1  s2 read strobe
- mem_write  out  1  constant 0
- mem_byteenable  out  DATA_W/8  constant all-ones
- mem_writedata  out  DATA_W  constant 0
- mem_readdata  in  DATA_W  s2 read data; valid exactly 1 cycle after mem_chipselect
- out_data  out  DATA_W  sample
- out_valid  out  1  sample valid
- out_ready  in  1  downstream accept
- out_startofpacket  out  1  marks the first sample of each block pass
- out_endofpacket  out  1  marks the last sample of each block pass

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: start=1 and stop=0 with latched length ≠ 0 -> RUN. Offset, packet and in-flight counters clear.
- start with length=0 -> stay IDLE; done pulses next cycle; no memory access.
- RUN, read issue:
  - mem_address = (base_addr + offset) mod 2^ADDR_W.
  - Each issued read increments offset.
  - Reads are issued into a 2-entry output FIFO under credit control.
  - A read may issue when (FIFO occupancy + reads in flight) < 2, or when a FIFO pop occurs in the same cycle.
  - The FIFO never overflows; readdata is never dropped.
- SOP is tagged on the sample with offset 0. EOP is tagged on the sample with offset length-1.
- At offset = length: if loop=1, offset returns to 0 and issuing continues without a bubble; otherwise issuing stops.
- RUN -> FLUSH (one-shot only) after the last read issues. FLUSH -> IDLE when the EOP sample is accepted (out_valid & out_ready). busy drops and done pulses in the cycle after that acceptance.
- stop, any state:
  - The next cycle goes to IDLE.
  - The FIFO and in-flight read are discarded; out_valid=0 and busy=0 from the next cycle.
  - No done pulse.
  - start asserted together with stop is ignored.
- start while busy: ignored. base_addr, length and loop changes while busy: ignored.
- out_data, SOP and EOP hold stable while out_valid=1 and out_ready=0.
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0. State is IDLE.
- Reset asserted mid-block: all outputs take their reset values immediately (asynchronously), and the block does not resume after release.

## Timing
- start in cycle 0:
  - cycle 1: mem_chipselect=1, mem_address=base_addr.
  - cycle 2: mem_readdata valid and captured.
  - cycle 3: out_valid=1 with sample base_addr.
- Start-to-first-sample latency is 3 cycles.
- With out_ready held 1: one sample per cycle sustained, including across loop boundaries.
- Backpressure: when out_ready falls, at most one further read issues. mem_chipselect is 0 while credit is exhausted.
- A one-shot block of N samples with out_ready=1: last sample appears in cycle N+2; done in cycle N+3.
- No combinational path from out_ready to mem_chipselect beyond the credit equation. All outputs are registered except mem_address and mem_chipselect, which are driven from registers.

## Test plan
- base=0x010, length=4, loop=0, ready=1; buffer preloaded with 0x1000+addr -> out_data 0x1010..0x1013 in cycles 3..6; SOP in cycle 3; EOP in cycle 6; done in cycle 7.
- Wrap: base=0x1FE, length=4 -> mem_address 0x1FE, 0x1FF, 0x000, 0x001; data order matches.
- Backpressure: length=8, out_ready toggling 1,0,0,1 repeating -> all 8 samples delivered once, in order, none duplicated; FIFO occupancy never exceeds 2.
- Loop: base=0, length=3, loop=1, ready=1 -> samples 0,1,2,0,1,2,... with no gap; SOP on every 0, EOP on every 2. stop after 7 accepted samples -> out_valid=0 and busy=0 next cycle; no done.
- Edges: length=0 -> done only; length=600 -> 512 samples; start held high while busy -> no restart.
- reset_n pulsed low mid-block -> all outputs at reset values immediately; stays IDLE after release until a new start.
